// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file and its operand lookup.
package reg_file_pkg;

    localparam int unsigned RF_REG_NUM = 32;
    localparam int unsigned RF_ROB_W   = 4;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned DATA_W     = 32;

    // Where an operand lookup found its answer, highest priority first.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_REG,
        SRC_COMMIT,
        SRC_ROB,
        SRC_WAIT
    } op_src_e;

endpackage

// File: rtl/reg_file_lookup.sv
// Combinational per-operand priority mux: x0, idle register, commit bypass, ROB answer, wait.
module reg_lookup
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_W = RF_ROB_W
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [DATA_W-1:0]    reg_val,
    input  logic                 reg_busy,
    input  logic [ROB_W-1:0]     reg_tag,
    input  logic                 commit_sgn,
    input  logic [REG_IDX_W-1:0] commit_dest,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic [ROB_W-1:0]     commit_tag,
    input  logic                 rob_rdy,
    input  logic [DATA_W-1:0]    rob_val,
    output logic                 rdy,
    output logic [DATA_W-1:0]    val,
    output logic [ROB_W-1:0]     tag
);

    op_src_e src;

    always_comb begin
        src = SRC_WAIT;
        if (rs == '0)
            src = SRC_ZERO;
        else if (!reg_busy)
            src = SRC_REG;
        else if (commit_sgn && commit_dest == rs && commit_tag == reg_tag)
            src = SRC_COMMIT;
        else if (rob_rdy)
            src = SRC_ROB;
    end

    always_comb begin
        rdy = 1'b1;
        val = '0;
        tag = reg_tag;
        case (src)
            SRC_ZERO:   val = '0;
            SRC_REG:    val = reg_val;
            SRC_COMMIT: val = commit_value;
            SRC_ROB:    val = rob_val;
            default:    rdy = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename status: operand lookup, rename at issue,
// write-back at commit, and flush of all pending renames on a mispredict.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM = RF_REG_NUM,
    parameter int unsigned ROB_W   = RF_ROB_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 IS_sgn,
    input  logic [REG_IDX_W-1:0] IS_rs1,
    input  logic [REG_IDX_W-1:0] IS_rs2,
    input  logic [REG_IDX_W-1:0] IS_rd,
    input  logic                 IS_has_rd,
    output logic                 IS_rdy1,
    output logic                 IS_rdy2,
    output logic [DATA_W-1:0]    IS_val1,
    output logic [DATA_W-1:0]    IS_val2,
    output logic [ROB_W-1:0]     IS_tag1,
    output logic [ROB_W-1:0]     IS_tag2,
    input  logic [ROB_W-1:0]     ROB_name,
    output logic [ROB_W-1:0]     ROB_ord1,
    output logic [ROB_W-1:0]     ROB_ord2,
    input  logic                 ROB_rdy1,
    input  logic                 ROB_rdy2,
    input  logic [DATA_W-1:0]    ROB_val1,
    input  logic [DATA_W-1:0]    ROB_val2,
    input  logic                 commit_sgn,
    input  logic [REG_IDX_W-1:0] commit_dest,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic [ROB_W-1:0]     commit_ROB_name,
    input  logic                 jp_wrong
);

    logic [DATA_W-1:0] val_q [REG_NUM];
    logic [DATA_W-1:0] val_d [REG_NUM];
    logic [ROB_W-1:0]  tag_q [REG_NUM];
    logic [ROB_W-1:0]  tag_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic commit_we;
    logic rename_we;

    assign commit_we = commit_sgn && (commit_dest != '0);
    assign rename_we = IS_sgn && IS_has_rd && (IS_rd != '0) && !jp_wrong;

    // Next state: commit writes value, rename overrides busy/tag, flush clears all busy.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (commit_we && commit_dest == REG_IDX_W'(i)) begin
                val_d[i] = commit_value;
                if (busy_q[i] && tag_q[i] == commit_ROB_name)
                    busy_d[i] = 1'b0;
            end
            if (rename_we && IS_rd == REG_IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = ROB_name;
            end
        end
        if (jp_wrong)
            busy_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            busy_q <= busy_d;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign ROB_ord1 = tag_q[IS_rs1];
    assign ROB_ord2 = tag_q[IS_rs2];

    reg_lookup #(.ROB_W(ROB_W)) u_lookup1 (
        .rs           (IS_rs1),
        .reg_val      (val_q[IS_rs1]),
        .reg_busy     (busy_q[IS_rs1]),
        .reg_tag      (tag_q[IS_rs1]),
        .commit_sgn   (commit_sgn),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_tag   (commit_ROB_name),
        .rob_rdy      (ROB_rdy1),
        .rob_val      (ROB_val1),
        .rdy          (IS_rdy1),
        .val          (IS_val1),
        .tag          (IS_tag1)
    );

    reg_lookup #(.ROB_W(ROB_W)) u_lookup2 (
        .rs           (IS_rs2),
        .reg_val      (val_q[IS_rs2]),
        .reg_busy     (busy_q[IS_rs2]),
        .reg_tag      (tag_q[IS_rs2]),
        .commit_sgn   (commit_sgn),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_tag   (commit_ROB_name),
        .rob_rdy      (ROB_rdy2),
        .rob_val      (ROB_val2),
        .rdy          (IS_rdy2),
        .val          (IS_val2),
        .tag          (IS_tag2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: lookup priority, rename, commit, flush, x0, hold and reset.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IS_sgn;
    logic [4:0]  IS_rs1, IS_rs2, IS_rd;
    logic        IS_has_rd;
    logic        IS_rdy1, IS_rdy2;
    logic [31:0] IS_val1, IS_val2;
    logic [3:0]  IS_tag1, IS_tag2;
    logic [3:0]  ROB_name;
    logic [3:0]  ROB_ord1, ROB_ord2;
    logic        ROB_rdy1, ROB_rdy2;
    logic [31:0] ROB_val1, ROB_val2;
    logic        commit_sgn;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic [3:0]  commit_ROB_name;
    logic        jp_wrong;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IS_sgn(IS_sgn), .IS_rs1(IS_rs1), .IS_rs2(IS_rs2), .IS_rd(IS_rd), .IS_has_rd(IS_has_rd),
        .IS_rdy1(IS_rdy1), .IS_rdy2(IS_rdy2), .IS_val1(IS_val1), .IS_val2(IS_val2),
        .IS_tag1(IS_tag1), .IS_tag2(IS_tag2),
        .ROB_name(ROB_name), .ROB_ord1(ROB_ord1), .ROB_ord2(ROB_ord2),
        .ROB_rdy1(ROB_rdy1), .ROB_rdy2(ROB_rdy2), .ROB_val1(ROB_val1), .ROB_val2(ROB_val2),
        .commit_sgn(commit_sgn), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_ROB_name(commit_ROB_name), .jp_wrong(jp_wrong)
    );

    task automatic idle();
        rdy = 1'b1; IS_sgn = 1'b0; IS_rs1 = '0; IS_rs2 = '0; IS_rd = '0; IS_has_rd = 1'b0;
        ROB_name = '0; ROB_rdy1 = 1'b0; ROB_rdy2 = 1'b0; ROB_val1 = '0; ROB_val2 = '0;
        commit_sgn = 1'b0; commit_dest = '0; commit_value = '0; commit_ROB_name = '0;
        jp_wrong = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #12;
        rst = 1'b1;
        #2;
        IS_rs1 = 5'd7; IS_rs2 = 5'd0;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL reset_rdy1 got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'h0) $display("FAIL reset_val1 got %h exp 0", IS_val1); else pass_cnt++;
        total_cnt++; if (IS_rdy2 !== 1'b1) $display("FAIL reset_rdy2 got %0b exp 1", IS_rdy2); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'h0) $display("FAIL reset_val2 got %h exp 0", IS_val2); else pass_cnt++;
        total_cnt++; if (ROB_ord1 !== 4'd0) $display("FAIL reset_ord1 got %0d exp 0", ROB_ord1); else pass_cnt++;
    endtask

    task automatic test_rename();
        idle();
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd5; ROB_name = 4'd3;
        tick();
        idle();
        IS_rs1 = 5'd5;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b0) $display("FAIL rename_rdy1 got %0b exp 0", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_tag1 !== 4'd3) $display("FAIL rename_tag1 got %0d exp 3", IS_tag1); else pass_cnt++;
        total_cnt++; if (ROB_ord1 !== 4'd3) $display("FAIL rename_ord1 got %0d exp 3", ROB_ord1); else pass_cnt++;
        ROB_rdy1 = 1'b1; ROB_val1 = 32'hDEAD;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL rob_fwd_rdy1 got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'hDEAD) $display("FAIL rob_fwd_val1 got %h exp dead", IS_val1); else pass_cnt++;
    endtask

    // Commit of tag 3 and rename to tag 9 of x5 in the same cycle; x5 also read as a source.
    task automatic test_commit_and_rename();
        idle();
        commit_sgn = 1'b1; commit_dest = 5'd5; commit_ROB_name = 4'd3; commit_value = 32'h1234;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd5; ROB_name = 4'd9; IS_rs1 = 5'd5;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL bypass_rdy1 got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'h1234) $display("FAIL bypass_val1 got %h exp 1234", IS_val1); else pass_cnt++;
        tick();
        idle();
        IS_rs1 = 5'd5;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b0) $display("FAIL rename_wins_rdy1 got %0b exp 0", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_tag1 !== 4'd9) $display("FAIL rename_wins_tag1 got %0d exp 9", IS_tag1); else pass_cnt++;
    endtask

    // Stale-tag commit to x5 plus rename of x6; then flush with a concurrent issue and commit.
    task automatic test_stale_commit_and_flush();
        idle();
        commit_sgn = 1'b1; commit_dest = 5'd5; commit_ROB_name = 4'd3; commit_value = 32'h5555;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd6; ROB_name = 4'd10; IS_rs1 = 5'd5;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b0) $display("FAIL stale_bypass_rdy1 got %0b exp 0", IS_rdy1); else pass_cnt++;
        tick();
        idle();
        IS_rs1 = 5'd5; IS_rs2 = 5'd6;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b0) $display("FAIL stale_busy_rdy1 got %0b exp 0", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_tag1 !== 4'd9) $display("FAIL stale_tag1 got %0d exp 9", IS_tag1); else pass_cnt++;
        total_cnt++; if (IS_tag2 !== 4'd10) $display("FAIL x6_tag2 got %0d exp 10", IS_tag2); else pass_cnt++;
        jp_wrong = 1'b1;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd7; ROB_name = 4'd11;
        commit_sgn = 1'b1; commit_dest = 5'd8; commit_ROB_name = 4'd0; commit_value = 32'hABCD;
        tick();
        idle();
        IS_rs1 = 5'd5; IS_rs2 = 5'd6;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL flush_x5_rdy got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'h5555) $display("FAIL flush_x5_val got %h exp 5555", IS_val1); else pass_cnt++;
        total_cnt++; if (IS_rdy2 !== 1'b1) $display("FAIL flush_x6_rdy got %0b exp 1", IS_rdy2); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'h0) $display("FAIL flush_x6_val got %h exp 0", IS_val2); else pass_cnt++;
        IS_rs1 = 5'd7; IS_rs2 = 5'd8;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL flush_x7_rdy got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'h0) $display("FAIL flush_x7_val got %h exp 0", IS_val1); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'hABCD) $display("FAIL flush_commit_x8 got %h exp abcd", IS_val2); else pass_cnt++;
    endtask

    task automatic test_x0();
        idle();
        commit_sgn = 1'b1; commit_dest = 5'd0; commit_ROB_name = 4'd0; commit_value = 32'hFF;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd0; ROB_name = 4'd2;
        tick();
        idle();
        IS_rs1 = 5'd0; ROB_rdy1 = 1'b1; ROB_val1 = 32'h77;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL x0_rdy got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val1 !== 32'h0) $display("FAIL x0_val got %h exp 0", IS_val1); else pass_cnt++;
        total_cnt++; if (ROB_ord1 !== 4'd0) $display("FAIL x0_ord got %0d exp 0", ROB_ord1); else pass_cnt++;
    endtask

    task automatic test_commit_clears_busy();
        idle();
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd12; ROB_name = 4'd5;
        tick();
        idle();
        commit_sgn = 1'b1; commit_dest = 5'd12; commit_ROB_name = 4'd5; commit_value = 32'h42;
        IS_rs2 = 5'd12;
        #1;
        total_cnt++; if (IS_val2 !== 32'h42) $display("FAIL commit_bypass_val2 got %h exp 42", IS_val2); else pass_cnt++;
        tick();
        idle();
        IS_rs2 = 5'd12; ROB_rdy2 = 1'b1; ROB_val2 = 32'h999;
        #1;
        total_cnt++; if (IS_rdy2 !== 1'b1) $display("FAIL commit_clear_rdy2 got %0b exp 1", IS_rdy2); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'h42) $display("FAIL reg_over_rob_val2 got %h exp 42", IS_val2); else pass_cnt++;
    endtask

    task automatic test_hold();
        idle();
        rdy = 1'b0;
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd9; ROB_name = 4'd4;
        commit_sgn = 1'b1; commit_dest = 5'd10; commit_ROB_name = 4'd0; commit_value = 32'h77;
        IS_rs1 = 5'd8;
        #1;
        total_cnt++; if (IS_val1 !== 32'hABCD) $display("FAIL hold_comb_val1 got %h exp abcd", IS_val1); else pass_cnt++;
        tick();
        idle();
        IS_rs1 = 5'd9; IS_rs2 = 5'd10;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL hold_no_rename got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'h0) $display("FAIL hold_no_commit got %h exp 0", IS_val2); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        idle();
        IS_sgn = 1'b1; IS_has_rd = 1'b1; IS_rd = 5'd13; ROB_name = 4'd6;
        tick();
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        IS_rs1 = 5'd13; IS_rs2 = 5'd8;
        #1;
        total_cnt++; if (IS_rdy1 !== 1'b1) $display("FAIL rst_mid_rdy1 got %0b exp 1", IS_rdy1); else pass_cnt++;
        total_cnt++; if (IS_val2 !== 32'h0) $display("FAIL rst_mid_val2 got %h exp 0", IS_val2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rename();
        test_commit_and_rename();
        test_stale_commit_and_flush();
        test_x0();
        test_commit_clears_busy();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
